// File: rtl/pwm_servo_pkg.sv
// Shared constants and FSM state type for the RC servo PWM decoder.
package pwm_servo_pkg;

  localparam int CLK_HZ            = 100_000_000;
  localparam int MIN_CYC_DEF       = 100_000;
  localparam int STEP_CYC_DEF      = 391;
  localparam int GLITCH_CYC_DEF    = 50_000;
  localparam int MAXVAL_CYC_DEF    = 300_000;
  localparam int TIMEOUT_CYC_DEF   = 2_500_000;
  localparam int DEFAULT_SERVO_DEF = 128;

  typedef enum logic [1:0] {
    WAIT_LOW  = 2'd0,
    WAIT_RISE = 2'd1,
    MEASURE   = 2'd2
  } state_e;

endpackage

// File: rtl/pwm_in_sync.sv
// Two-flop synchronizer for the asynchronous PWM pin plus rise/fall detection.
module pwm_in_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_pin,
  output logic o_s2,
  output logic o_rise,
  output logic o_fall
);

  logic r_s1;
  logic r_s2;
  logic r_s2_d;

  // Reset to high so a pin that is already high after reset is seen as
  // mid-pulse and no spurious rise edge is produced.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1   <= 1'b1;
      r_s2   <= 1'b1;
      r_s2_d <= 1'b1;
    end else begin
      r_s1   <= i_pin;
      r_s2   <= r_s1;
      r_s2_d <= r_s2;
    end
  end

  assign o_s2   = r_s2;
  assign o_rise = r_s2 & ~r_s2_d;
  assign o_fall = ~r_s2 & r_s2_d;

endmodule

// File: rtl/pwm_to_servo.sv
// Measures servo PWM high time and maps MIN..MIN+256*STEP cycles onto 0..255,
// flagging out-of-range pulses and loss of signal.
module pwm_to_servo
  import pwm_servo_pkg::*;
#(
  parameter int MIN_CYC       = MIN_CYC_DEF,
  parameter int STEP_CYC      = STEP_CYC_DEF,
  parameter int GLITCH_CYC    = GLITCH_CYC_DEF,
  parameter int MAXVAL_CYC    = MAXVAL_CYC_DEF,
  parameter int TIMEOUT_CYC   = TIMEOUT_CYC_DEF,
  parameter int DEFAULT_SERVO = DEFAULT_SERVO_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pwm_in,
  output logic [7:0] servo,
  output logic       servo_valid,
  output logic       pulse_err,
  output logic       signal_lost,
  output logic [1:0] dbg_state
);

  localparam logic [21:0] L_MIN     = 22'(MIN_CYC);
  localparam logic [21:0] L_GLITCH  = 22'(GLITCH_CYC);
  localparam logic [21:0] L_MAXVAL  = 22'(MAXVAL_CYC);
  localparam logic [21:0] L_TIMEOUT = 22'(TIMEOUT_CYC);
  localparam logic [8:0]  L_STEP_M1 = 9'(STEP_CYC - 1);
  localparam logic [7:0]  L_DEFAULT = 8'(DEFAULT_SERVO);

  logic w_s2;
  logic w_rise;
  logic w_fall;

  pwm_in_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .i_pin  (pwm_in),
    .o_s2   (w_s2),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  state_e      r_state;
  logic [21:0] r_width;
  logic [8:0]  r_pre;
  logic [7:0]  r_steps;
  logic [21:0] r_tcnt;

  logic w_eval;
  logic w_in_range;
  logic w_accept;
  logic w_reject;

  assign w_eval     = (r_state == MEASURE) && w_fall;
  assign w_in_range = (r_width >= L_GLITCH) && (r_width <= L_MAXVAL);
  assign w_accept   = w_eval && w_in_range;
  assign w_reject   = w_eval && !w_in_range;
  assign dbg_state  = r_state;

  // Width counts high cycles; steps is the quotient (width-MIN)/STEP built
  // incrementally by the pre counter, so no divider is needed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= WAIT_LOW;
      r_width <= '0;
      r_pre   <= '0;
      r_steps <= '0;
    end else begin
      case (r_state)
        WAIT_LOW: begin
          if (!w_s2) r_state <= WAIT_RISE;
        end
        WAIT_RISE: begin
          if (w_rise) begin
            r_width <= 22'd1;
            r_pre   <= '0;
            r_steps <= '0;
            r_state <= MEASURE;
          end
        end
        MEASURE: begin
          if (w_fall) begin
            r_state <= WAIT_RISE;
          end else if (w_s2) begin
            if (r_width <= L_MAXVAL) r_width <= r_width + 22'd1;
            if (r_width >= L_MIN) begin
              if (r_pre == L_STEP_M1) begin
                r_pre <= '0;
                if (r_steps != 8'hFF) r_steps <= r_steps + 8'd1;
              end else begin
                r_pre <= r_pre + 9'd1;
              end
            end
          end
        end
        default: r_state <= WAIT_LOW;
      endcase
    end
  end

  // An accepted pulse takes priority over a timeout in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      servo       <= L_DEFAULT;
      servo_valid <= 1'b0;
      pulse_err   <= 1'b0;
      signal_lost <= 1'b0;
      r_tcnt      <= '0;
    end else begin
      servo_valid <= w_accept;
      pulse_err   <= w_reject;
      if (w_accept) begin
        servo       <= r_steps;
        r_tcnt      <= '0;
        signal_lost <= 1'b0;
      end else if (r_tcnt >= L_TIMEOUT) begin
        signal_lost <= 1'b1;
        servo       <= L_DEFAULT;
      end else begin
        r_tcnt <= r_tcnt + 22'd1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_to_servo.sv
// Bench for pwm_to_servo with scaled-down timing parameters; expectations come
// from a plain arithmetic model of the pulse-width to servo mapping.
module tb_pwm_to_servo;

  localparam int MIN_CYC       = 200;
  localparam int STEP_CYC      = 3;
  localparam int GLITCH_CYC    = 100;
  localparam int MAXVAL_CYC    = 1000;
  localparam int TIMEOUT_CYC   = 10000;
  localparam int DEFAULT_SERVO = 128;

  logic       clk;
  logic       rst;
  logic       pwm_in;
  logic [7:0] servo;
  logic       servo_valid;
  logic       pulse_err;
  logic       signal_lost;
  logic [1:0] dbg_state;

  int checks   = 0;
  int failures = 0;
  int n_both   = 0;
  logic [7:0] exp_servo;

  pwm_to_servo #(
    .MIN_CYC       (MIN_CYC),
    .STEP_CYC      (STEP_CYC),
    .GLITCH_CYC    (GLITCH_CYC),
    .MAXVAL_CYC    (MAXVAL_CYC),
    .TIMEOUT_CYC   (TIMEOUT_CYC),
    .DEFAULT_SERVO (DEFAULT_SERVO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pwm_in      (pwm_in),
    .servo       (servo),
    .servo_valid (servo_valid),
    .pulse_err   (pulse_err),
    .signal_lost (signal_lost),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model
  function automatic int model_servo(input int w);
    int s;
    if (w < MIN_CYC) return 0;
    s = (w - MIN_CYC) / STEP_CYC;
    return (s > 255) ? 255 : s;
  endfunction

  function automatic bit model_accept(input int w);
    return (w >= GLITCH_CYC) && (w <= MAXVAL_CYC);
  endfunction

  // driver: pin high for w cycles, low, then an 8-cycle observation window and gap
  task automatic pulse(input int w, input int gap,
                       output int nv, output int ne, output int lat);
    nv = 0; ne = 0; lat = 0;
    pwm_in = 1'b1;
    for (int i = 0; i < w; i++) begin
      @(negedge clk);
      if (servo_valid) nv++;
      if (pulse_err) ne++;
      if (servo_valid && pulse_err) n_both++;
    end
    pwm_in = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (servo_valid || pulse_err) begin
        if (lat == 0) lat = i;
      end
      if (servo_valid) nv++;
      if (pulse_err) ne++;
      if (servo_valid && pulse_err) n_both++;
    end
    repeat (gap) @(negedge clk);
  endtask

  task automatic test_reset;
    int nv, ne, lat;
    rst = 1'b1;
    pwm_in = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (servo !== 8'(DEFAULT_SERVO) || servo_valid !== 1'b0 || pulse_err !== 1'b0 ||
        signal_lost !== 1'b0 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL reset_values: servo=%0d v=%b e=%b lost=%b st=%0d required 128/0/0/0/0",
               servo, servo_valid, pulse_err, signal_lost, dbg_state);
    end
    rst = 1'b0;
    exp_servo = 8'(DEFAULT_SERVO);
    pulse(350, 20, nv, ne, lat);
    checks++;
    if (nv !== 0 || ne !== 0 || servo !== exp_servo) begin
      failures++;
      $display("FAIL partial_pulse_ignored: valid=%0d err=%0d servo=%0d required 0/0/%0d",
               nv, ne, servo, exp_servo);
    end
    pulse(350, 20, nv, ne, lat);
    exp_servo = 8'(model_servo(350));
    checks++;
    if (nv !== 1 || ne !== 0 || servo !== exp_servo) begin
      failures++;
      $display("FAIL first_full_pulse: valid=%0d err=%0d servo=%0d required 1/0/%0d",
               nv, ne, servo, exp_servo);
    end
    checks++;
    if (lat !== 3) begin
      failures++;
      $display("FAIL valid_latency: got %0d cycles required 3", lat);
    end
  endtask

  task automatic test_boundaries;
    int widths[8] = '{200, 202, 203, 964, 965, 1000, 100, 500};
    int nv, ne, lat;
    foreach (widths[k]) begin
      pulse(widths[k], 12, nv, ne, lat);
      exp_servo = 8'(model_servo(widths[k]));
      checks++;
      if (nv !== 1 || ne !== 0 || servo !== exp_servo || lat !== 3) begin
        failures++;
        $display("FAIL boundary_w%0d: valid=%0d err=%0d servo=%0d lat=%0d required 1/0/%0d/3",
                 widths[k], nv, ne, servo, lat, exp_servo);
      end
    end
  endtask

  task automatic test_reject;
    int widths[3] = '{99, 1001, 1090};
    int nv, ne, lat;
    foreach (widths[k]) begin
      pulse(widths[k], 12, nv, ne, lat);
      checks++;
      if (nv !== 0 || ne !== 1 || servo !== exp_servo || lat !== 3) begin
        failures++;
        $display("FAIL reject_w%0d: valid=%0d err=%0d servo=%0d lat=%0d required 0/1/%0d/3",
                 widths[k], nv, ne, servo, lat, exp_servo);
      end
    end
  endtask

  task automatic test_random;
    int w, gap, nv, ne, lat;
    for (int k = 0; k < 25; k++) begin
      w   = $urandom_range(60, 1100);
      gap = $urandom_range(0, 30);
      pulse(w, gap, nv, ne, lat);
      if (model_accept(w)) begin
        exp_servo = 8'(model_servo(w));
        checks++;
        if (nv !== 1 || ne !== 0 || servo !== exp_servo) begin
          failures++;
          $display("FAIL random_accept_w%0d: valid=%0d err=%0d servo=%0d required 1/0/%0d",
                   w, nv, ne, servo, exp_servo);
        end
      end else begin
        checks++;
        if (nv !== 0 || ne !== 1 || servo !== exp_servo) begin
          failures++;
          $display("FAIL random_reject_w%0d: valid=%0d err=%0d servo=%0d required 0/1/%0d",
                   w, nv, ne, servo, exp_servo);
        end
      end
    end
  endtask

  task automatic test_glitch_timeout;
    int nv, ne, lat, elapsed;
    pulse(360, 0, nv, ne, lat);
    exp_servo = 8'(model_servo(360));
    checks++;
    if (nv !== 1 || servo !== exp_servo || signal_lost !== 1'b0) begin
      failures++;
      $display("FAIL pre_timeout_pulse: valid=%0d servo=%0d lost=%b required 1/%0d/0",
               nv, servo, signal_lost, exp_servo);
    end
    elapsed = 8 - lat;
    for (int g = 0; g < 3; g++) begin
      pulse(1, 20, nv, ne, lat);
      elapsed += 29;
      checks++;
      if (nv !== 0 || ne !== 1 || servo !== exp_servo) begin
        failures++;
        $display("FAIL glitch_%0d: valid=%0d err=%0d servo=%0d required 0/1/%0d",
                 g, nv, ne, servo, exp_servo);
      end
    end
    repeat (TIMEOUT_CYC - 1 - elapsed) @(negedge clk);
    checks++;
    if (signal_lost !== 1'b0 || servo !== exp_servo) begin
      failures++;
      $display("FAIL timeout_early: lost=%b servo=%0d required 0/%0d", signal_lost, servo, exp_servo);
    end
    repeat (2) @(negedge clk);
    exp_servo = 8'(DEFAULT_SERVO);
    checks++;
    if (signal_lost !== 1'b1 || servo !== exp_servo) begin
      failures++;
      $display("FAIL timeout_reached: lost=%b servo=%0d required 1/%0d", signal_lost, servo, exp_servo);
    end
    pulse(360, 10, nv, ne, lat);
    exp_servo = 8'(model_servo(360));
    checks++;
    if (nv !== 1 || signal_lost !== 1'b0 || servo !== exp_servo) begin
      failures++;
      $display("FAIL timeout_recover: valid=%0d lost=%b servo=%0d required 1/0/%0d",
               nv, signal_lost, servo, exp_servo);
    end
  endtask

  task automatic test_reset_mid;
    int nv, ne, lat, bad;
    bad = 0;
    pwm_in = 1'b1;
    repeat (500) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_servo = 8'(DEFAULT_SERVO);
    checks++;
    if (servo !== exp_servo || servo_valid !== 1'b0 || pulse_err !== 1'b0 ||
        signal_lost !== 1'b0 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL reset_mid_values: servo=%0d v=%b e=%b lost=%b st=%0d required 128/0/0/0/0",
               servo, servo_valid, pulse_err, signal_lost, dbg_state);
    end
    pulse(300, 15, nv, ne, lat);
    checks++;
    if (nv !== 0 || ne !== 0 || servo !== exp_servo) begin
      failures++;
      $display("FAIL reset_mid_aborted: valid=%0d err=%0d servo=%0d required 0/0/%0d",
               nv, ne, servo, exp_servo);
    end
    pulse(650, 15, nv, ne, lat);
    exp_servo = 8'(model_servo(650));
    checks++;
    if (nv !== 1 || ne !== 0 || servo !== exp_servo || lat !== 3) begin
      failures++;
      $display("FAIL reset_mid_resume: valid=%0d err=%0d servo=%0d lat=%0d required 1/0/%0d/3",
               nv, ne, servo, lat, exp_servo);
    end
  endtask

  task automatic test_back_to_back;
    int w, nv, ne, lat;
    for (int k = 0; k < 6; k++) begin
      w = $urandom_range(100, 1000);
      pulse(w, 0, nv, ne, lat);
      exp_servo = 8'(model_servo(w));
      checks++;
      if (nv !== 1 || ne !== 0 || servo !== exp_servo) begin
        failures++;
        $display("FAIL back_to_back_w%0d: valid=%0d err=%0d servo=%0d required 1/0/%0d",
                 w, nv, ne, servo, exp_servo);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    pwm_in = 1'b0;
    exp_servo = 8'(DEFAULT_SERVO);
    repeat (2) @(negedge clk);
    test_reset();
    test_boundaries();
    test_reject();
    test_random();
    test_glitch_timeout();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (n_both !== 0) begin
      failures++;
      $display("FAIL valid_err_exclusive: overlapping cycles=%0d required 0", n_both);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
